// File: rtl/clock_period_detector_pkg.sv
// Shared state encoding, lock-counter width and saturating arithmetic for
// clock_period_detector.
package clock_period_detector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE
  } state_t;

  localparam int unsigned LOCK_W = 8;

  // Adds inc to val and clamps the result at 2^width-1.
  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [31:0] lim;
    lim = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    sum = {1'b0, val} + {1'b0, inc};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/clock_sync_rise.sv
// Multi-flop synchronizer for an asynchronous clock-like input, followed by a
// registered rising-edge detector; s and rise are aligned to the same cycle.
module clock_sync_rise #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      s    <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s    <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~s;
    end
  end

endmodule

// File: rtl/clock_period_detector.sv
// Measures period and high time of a sampled clock-like input, checks limits
// and reports lock. Define CLOCK_PERIOD_DETECTOR_MINMAX_EN to track extremes.
module clock_period_detector
  import clock_period_detector_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] min_period,
  input  logic [CNT_W-1:0] max_period,
  input  logic             err_clear,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_sat,
  output logic             meas_lost,
  output logic             err_short,
  output logic             err_long,
  output logic             locked,
  output logic [CNT_W-1:0] obs_min,
  output logic [CNT_W-1:0] obs_max
);

  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

  logic              s;
  logic              rise;
  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hi;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  hi_inc;
  logic              long_seen;
  logic [LOCK_W-1:0] lock_cnt;
  logic              first_rise;
  logic              report;
  logic              long_evt;
  logic              over_max;
  logic              short_evt;
  logic              in_range;
  logic              lost_evt;
  logic              load;

  clock_sync_rise #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise)
  );

  // cnt_inc is both the running period for the long check and P at report
  assign cnt_inc   = CNT_W'(sat_add(32'(cnt), 32'd1, CNT_W));
  assign hi_inc    = CNT_W'(sat_add(32'(hi), 32'(s), CNT_W));
  assign over_max  = (max_period != '0) && (cnt_inc > max_period);
  assign short_evt = report && (cnt_inc < min_period);
  assign in_range  = report && !short_evt && !over_max;
  assign lost_evt  = report && meas_valid && !meas_ready;
  assign load      = report && (!meas_valid || meas_ready);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    first_rise = 1'b0;
    report     = 1'b0;
    long_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_n = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_n    = MEASURE;
          first_rise = 1'b1;
        end
      end
      MEASURE: begin
        report   = rise;
        long_evt = over_max && !long_seen;
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n    = IDLE;
      first_rise = 1'b0;
      report     = 1'b0;
      long_evt   = 1'b0;
    end
  end

  // Period/high counters; a rise restarts both with the rise cycle counted high
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt       <= '0;
      hi        <= '0;
      long_seen <= 1'b0;
    end else if (first_rise || report) begin
      cnt       <= '0;
      hi        <= CNT_W'(1);
      long_seen <= 1'b0;
    end else if (state == MEASURE) begin
      cnt <= cnt_inc;
      hi  <= hi_inc;
      if (long_evt) long_seen <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable || short_evt || long_evt) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (in_range) begin
      if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LOCK_W'(1);
      if (lock_cnt >= LOCK_MAX - LOCK_W'(1)) locked <= 1'b1;
    end
  end

  // Single-entry result register; held stable until accepted
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_sat    <= 1'b0;
    end else if (load) begin
      meas_valid  <= 1'b1;
      meas_period <= cnt_inc;
      meas_high   <= hi;
      meas_sat    <= &cnt_inc;
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meas_lost <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      meas_lost <= lost_evt  | (meas_lost & ~err_clear);
      err_short <= short_evt | (err_short & ~err_clear);
      err_long  <= long_evt  | (err_long  & ~err_clear);
    end
  end

`ifdef CLOCK_PERIOD_DETECTOR_MINMAX_EN
  logic [CNT_W-1:0] min_trk;
  logic [CNT_W-1:0] min_base;
  logic [CNT_W-1:0] max_base;
  logic [CNT_W-1:0] min_next;
  logic [CNT_W-1:0] max_next;
  logic             obs_clr;

  // Clearing happens first so a report in the same cycle seeds the new window
  always_comb begin
    obs_clr  = err_clear || !enable;
    min_base = obs_clr ? '1 : min_trk;
    max_base = obs_clr ? '0 : obs_max;
    min_next = min_base;
    max_next = max_base;
    if (report) begin
      if (cnt_inc < min_base) min_next = cnt_inc;
      if (cnt_inc > max_base) max_next = cnt_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      min_trk <= '1;
      obs_min <= '0;
      obs_max <= '0;
    end else begin
      min_trk <= min_next;
      obs_max <= max_next;
      if (report)       obs_min <= min_next;
      else if (obs_clr) obs_min <= '0;
    end
  end
`else
  assign obs_min = '0;
  assign obs_max = '0;
`endif

endmodule

// File: tb/tb_clock_period_detector.sv
// Self-checking bench for clock_period_detector: timestamp-based reference
// model compared every cycle plus directed literal checks.
module tb_clock_period_detector;

  localparam int W     = 16;
  localparam int MAXV  = 65535;
  localparam int LOCKN = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          sig_in = 1'b0;
  logic [W-1:0]  min_period = '0;
  logic [W-1:0]  max_period = '0;
  logic          err_clear = 1'b0;
  logic          meas_ready = 1'b1;
  logic          meas_valid;
  logic [W-1:0]  meas_period;
  logic [W-1:0]  meas_high;
  logic          meas_sat;
  logic          meas_lost;
  logic          err_short;
  logic          err_long;
  logic          locked;
  logic [W-1:0]  obs_min;
  logic [W-1:0]  obs_max;

  logic [3:0]    d4_min = '0;
  logic [3:0]    d4_max = '0;
  logic          d4_valid;
  logic [3:0]    d4_period;
  logic [3:0]    d4_high;
  logic          d4_sat;
  logic          d4_lost;
  logic          d4_short;
  logic          d4_long;
  logic          d4_locked;
  logic [3:0]    d4_omin;
  logic [3:0]    d4_omax;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  bit clr_req = 1'b0;

  always #5 clock = ~clock;

  clock_period_detector dut (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .min_period(min_period), .max_period(max_period), .err_clear(err_clear),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_period(meas_period),
    .meas_high(meas_high), .meas_sat(meas_sat), .meas_lost(meas_lost),
    .err_short(err_short), .err_long(err_long), .locked(locked),
    .obs_min(obs_min), .obs_max(obs_max)
  );

  clock_period_detector #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .min_period(d4_min), .max_period(d4_max), .err_clear(err_clear),
    .meas_valid(d4_valid), .meas_ready(meas_ready), .meas_period(d4_period),
    .meas_high(d4_high), .meas_sat(d4_sat), .meas_lost(d4_lost),
    .err_short(d4_short), .err_long(d4_long), .locked(d4_locked),
    .obs_min(d4_omin), .obs_max(d4_omax)
  );

  // Reference model state: timestamps of accepted rises, history of samples
  bit vq[$];
  int e = 0;
  bit active, lflag, mvalid, msat, mlost, mshort, mlong, mlocked;
  int lr, lockc, mperiod, mhigh, trk, omin, omax;

  function automatic bit vget(input int i);
    if (i < 0 || i >= vq.size()) return 1'b0;
    return vq[i];
  endfunction

  always @(posedge clock) begin
    int p, h, cp1, mn, mx;
    bit rise_b, rep, lev, sev, inr, lost;
    vq.push_back(sig_in);
    mn = int'(min_period);
    mx = int'(max_period);
    if (reset) begin
      for (int k = 0; k < 4; k++) if (e - k >= 0) vq[e-k] = 1'b0;
      active = 0; lr = -1; lflag = 0; lockc = 0; mlocked = 0;
      mvalid = 0; mperiod = 0; mhigh = 0; msat = 0;
      mlost = 0; mshort = 0; mlong = 0; trk = MAXV; omin = 0; omax = 0;
    end else begin
      rep = 0; lev = 0; sev = 0; inr = 0; p = 0; h = 0;
      // synced sample seen at edge j is the input sampled three edges earlier
      rise_b = vget(e - 3) & ~vget(e - 4);
      if (!enable) begin
        active = 0; lr = -1; lflag = 0;
      end else if (!active) begin
        active = 1;
      end else if (lr < 0) begin
        if (rise_b) lr = e;
      end else begin
        cp1 = (e - lr > MAXV) ? MAXV : e - lr;
        if (mx != 0 && cp1 > mx && !lflag) begin lev = 1; lflag = 1; end
        if (rise_b) begin
          rep = 1;
          p = cp1;
          for (int j = lr; j < e; j++) h += int'(vget(j - 3));
          if (h > MAXV) h = MAXV;
          sev = (p < mn);
          inr = !sev && !(mx != 0 && p > mx);
          lr = e;
          lflag = 0;
        end
      end
      if (!enable || sev || lev) begin
        lockc = 0; mlocked = 0;
      end else if (inr) begin
        if (lockc < LOCKN) lockc++;
        mlocked = (lockc == LOCKN);
      end
      lost = rep && mvalid && !meas_ready;
      if (!enable) begin
        mvalid = 0; mperiod = 0; mhigh = 0; msat = 0;
      end else if (rep && (!mvalid || meas_ready)) begin
        mvalid = 1; mperiod = p; mhigh = h; msat = (p == MAXV);
      end else if (mvalid && meas_ready) begin
        mvalid = 0;
      end
      mlost  = lost | (mlost  & !err_clear);
      mshort = sev  | (mshort & !err_clear);
      mlong  = lev  | (mlong  & !err_clear);
`ifdef CLOCK_PERIOD_DETECTOR_MINMAX_EN
      if (err_clear || !enable) begin trk = MAXV; omin = 0; omax = 0; end
      if (rep) begin
        if (p < trk) trk = p;
        omin = trk;
        if (p > omax) omax = p;
      end
`endif
    end
    e++;
  end

  always @(negedge clock) begin
    logic [69:0] act_v, exp_v;
    if (e > 0) begin
      act_v = {meas_valid, meas_sat, meas_lost, err_short, err_long, locked,
               meas_period, meas_high, obs_min, obs_max};
      exp_v = {mvalid, msat, mlost, mshort, mlong, mlocked,
               16'(mperiod), 16'(mhigh), 16'(omin), 16'(omax)};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle %0d outputs: got %h want %h", e, act_v, exp_v);
      end
      if (meas_valid === 1'b1) vcnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v);
    @(negedge clock);
    sig_in    = v;
    err_clear = clr_req;
    clr_req   = 1'b0;
  endtask

  task automatic run_periods(input int per, input int high, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++) cyc(i < high);
  endtask

  task automatic pulse_clear();
    clr_req = 1'b1;
    cyc(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc(1'b0);
    check("reset_valid", int'(meas_valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_obs_min", int'(obs_min), 0);
    reset = 1'b0;
    enable = 1'b1;
    cyc(1'b0);

    // basic: period 10, high 4
    vcnt = 0;
    run_periods(10, 4, 3);
    check("basic_valid_count", vcnt, 2);
    check("basic_period", int'(meas_period), 10);
    check("basic_high", int'(meas_high), 4);

    // short periods
    min_period = 16'd8;
    run_periods(6, 3, 4);
    check("short_flag", int'(err_short), 1);
    check("short_locked", int'(locked), 0);
    run_periods(10, 4, 1);
    pulse_clear();
    run_periods(10, 4, 6);
    check("short_cleared", int'(err_short), 0);
    check("lock_after_good", int'(locked), 1);

    // stall with upper limit
    max_period = 16'd20;
    repeat (30) cyc(1'b0);
    check("stall_err_long", int'(err_long), 1);
    check("stall_unlocked", int'(locked), 0);

    // backpressure
    pulse_clear();
    min_period = '0;
    max_period = '0;
    enable = 1'b0;
    cyc(1'b0);
    enable = 1'b1;
    meas_ready = 1'b0;
    run_periods(5, 2, 4);
    check("bp_valid", int'(meas_valid), 1);
    check("bp_period", int'(meas_period), 5);
    check("bp_high", int'(meas_high), 2);
    check("bp_lost", int'(meas_lost), 1);
    meas_ready = 1'b1;
    cyc(1'b0);
    check("bp_consumed", int'(meas_valid), 0);
    pulse_clear();

    // saturation in the 4-bit instance
    run_periods(20, 5, 4);
    check("sat16_period", int'(meas_period), 20);
    check("sat16_sat", int'(meas_sat), 0);
    check("sat4_period", int'(d4_period), 15);
    check("sat4_high", int'(d4_high), 5);
    check("sat4_sat", int'(d4_sat), 1);

    // reset mid-measurement
    run_periods(10, 4, 1);
    run_periods(10, 4, 1);
    reset = 1'b1;
    cyc(1'b0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_period", int'(meas_period), 0);
    check("rst_locked", int'(locked), 0);
    reset = 1'b0;
    run_periods(10, 4, 2);
    check("after_rst_period", int'(meas_period), 10);

    // enable drop mid-measurement
    for (int i = 0; i < 7; i++) cyc(i < 4);
    enable = 1'b0;
    cyc(1'b0);
    check("dis_valid", int'(meas_valid), 0);
    check("dis_period", int'(meas_period), 0);
    enable = 1'b1;
    run_periods(10, 4, 2);
    check("reen_period", int'(meas_period), 10);

    // extremes
    pulse_clear();
    run_periods(9, 4, 1);
    run_periods(11, 4, 1);
    run_periods(10, 4, 1);
    run_periods(10, 4, 1);
    check("ext_period", int'(meas_period), 10);
`ifdef CLOCK_PERIOD_DETECTOR_MINMAX_EN
    check("obs_min", int'(obs_min), 9);
    check("obs_max", int'(obs_max), 11);
`else
    check("obs_min_tied", int'(obs_min), 0);
    check("obs_max_tied", int'(obs_max), 0);
`endif
    repeat (3) cyc(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
